sim_control_fsm: RTL and testbench

SIM_CONTROL_FSM -- requirements
Module: sim_control_fsm

---
 rtl/sim_control_fsm.sv | 162 ++++++++++++++++
 tb/tb_sim_control_fsm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sim_control_fsm.sv
// sim_control_fsm -- run controller for the network simulation datapath.
//
// Sequences one simulation run: IDLE -> SIMULATE -> DONE. In SIMULATE it
// strobes the next/last state registers every cycle and counts completed
// iterations. The iteration count stops at the latched max_iter. It also
// tracks consecutive steady iterations and flags steady_state once
// STEADY_HOLD of them have completed in a row.
//
// Update modes (latched at start):
//   0 synchronous        : one iteration per SIMULATE cycle
//   1 random-async       : as 0, plus en_rng every SIMULATE cycle
//   2 round-robin-async  : elem_sel walks 0..NUM_ELEM-1, one iteration per wrap
//   3                    : behaves as 0
//
// Optional build macro:
//   STEADY_EXIT_EN -- reaching STEADY_HOLD also ends the run (goes to DONE on
//                     the same edge that steady_state rises).
//
// Ports:
//   clk, rst            clock / async active-high reset
//   start               begin a run (sampled in IDLE and DONE only)
//   abort               end the current run, return to IDLE
//   mode[1:0]           update scheme, latched at start
//   max_iter[ITER_W]    iteration limit, latched at start
//   is_steady_state     datapath: next state equals last state
//   en_rng              advance RNG (SIMULATE, mode 1)
//   ld_next_state       load next-state register (SIMULATE)
//   ld_last_state       load last-state register (SIMULATE)
//   elem_sel[ELEM_W]    element under update in round-robin mode
//   steady_state        steady state confirmed (registered, sticky)
//   busy / done         in SIMULATE / in DONE
//   iteration_number    completed iterations in the current run
module sim_control_fsm #(
  parameter int ITER_W      = 10,
  parameter int NUM_ELEM    = 16,
  parameter int STEADY_HOLD = 4,
  localparam int ELEM_W     = $clog2(NUM_ELEM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              is_steady_state,
  output logic              en_rng,
  output logic              ld_next_state,
  output logic              ld_last_state,
  output logic [ELEM_W-1:0] elem_sel,
  output logic              steady_state,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iteration_number
);

  localparam int CNT_W = $clog2(STEADY_HOLD + 1);
  localparam logic [CNT_W-1:0]  HOLD      = CNT_W'(STEADY_HOLD);
  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SIMULATE = 2'b01,
    DONE     = 2'b10
  } state_t;

  state_t            state, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ITER_W-1:0] max_q, max_d;
  logic [ITER_W-1:0] iter_d;
  logic [ELEM_W-1:0] elem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ss_d;
  logic              iter_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      mode_q           <= 2'd0;
      max_q            <= '0;
      iteration_number <= '0;
      elem_sel         <= '0;
      cnt_q            <= '0;
      steady_state     <= 1'b0;
    end else begin
      state            <= state_d;
      mode_q           <= mode_d;
      max_q            <= max_d;
      iteration_number <= iter_d;
      elem_sel         <= elem_d;
      cnt_q            <= cnt_d;
      steady_state     <= ss_d;
    end
  end

  always_comb begin
    state_d       = state;
    mode_d        = mode_q;
    max_d         = max_q;
    iter_d        = iteration_number;
    elem_d        = elem_sel;
    cnt_d         = cnt_q;
    ss_d          = steady_state;
    en_rng        = 1'b0;
    ld_next_state = 1'b0;
    ld_last_state = 1'b0;
    iter_done     = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          mode_d  = mode;
          max_d   = max_iter;
          iter_d  = '0;
          elem_d  = '0;
          cnt_d   = '0;
          ss_d    = 1'b0;
          state_d = (max_iter == '0) ? DONE : SIMULATE;
        end else if (abort) begin
          state_d = IDLE;
          ss_d    = 1'b0;
        end
      end

      SIMULATE: begin
        ld_next_state = 1'b1;
        ld_last_state = 1'b1;
        en_rng        = (mode_q == 2'd1);
        if (abort) begin
          // abort wins over completion and the max_iter exit
          state_d = IDLE;
          ss_d    = 1'b0;
        end else begin
          if (mode_q == 2'd2) begin
            iter_done = (elem_sel == ELEM_LAST);
            elem_d    = iter_done ? '0 : elem_sel + 1'b1;
          end else begin
            iter_done = 1'b1;
          end

          if (iter_done) begin
            iter_d = iteration_number + 1'b1;
            if (!is_steady_state)  cnt_d = '0;
            else if (cnt_q != HOLD) cnt_d = cnt_q + 1'b1;
            if (cnt_d == HOLD) ss_d = 1'b1;
            // max_q >= 1 here, so max_q - 1 cannot underflow
            if (iteration_number == max_q - 1'b1) state_d = DONE;
`ifdef STEADY_EXIT_EN
            // only the edge that first reaches HOLD ends the run
            if (is_steady_state && cnt_q == HOLD - 1'b1) state_d = DONE;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == SIMULATE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sim_control_fsm.sv
module tb_sim_control_fsm;

  localparam int ITER_W = 10;
  localparam int NUM_ELEM = 16;
  localparam int STEADY_HOLD = 4;
  localparam int ELEM_W = $clog2(NUM_ELEM);
`ifdef STEADY_EXIT_EN
  localparam bit EXIT = 1'b1;
`else
  localparam bit EXIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [ITER_W-1:0] max_iter;
  logic              is_steady_state;
  logic              en_rng;
  logic              ld_next_state;
  logic              ld_last_state;
  logic [ELEM_W-1:0] elem_sel;
  logic              steady_state;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iteration_number;

  int passed = 0;
  int total  = 0;

  sim_control_fsm #(.ITER_W(ITER_W), .NUM_ELEM(NUM_ELEM), .STEADY_HOLD(STEADY_HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .max_iter(max_iter), .is_steady_state(is_steady_state),
    .en_rng(en_rng), .ld_next_state(ld_next_state), .ld_last_state(ld_last_state),
    .elem_sel(elem_sel), .steady_state(steady_state), .busy(busy), .done(done),
    .iteration_number(iteration_number)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // checks the always-visible status outputs in one go
  task automatic chk_status(input string tag, input logic b, input logic d,
                            input logic [ITER_W-1:0] it, input logic ss);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".iter"}, 32'(iteration_number), 32'(it));
    chk({tag, ".steady"}, 32'(steady_state), 32'(ss));
  endtask

  task automatic chk_strobes(input string tag, input logic ld, input logic rng);
    chk({tag, ".ld_next"}, 32'(ld_next_state), 32'(ld));
    chk({tag, ".ld_last"}, 32'(ld_last_state), 32'(ld));
    chk({tag, ".en_rng"}, 32'(en_rng), 32'(rng));
  endtask

  task automatic do_start(input logic [1:0] m, input logic [ITER_W-1:0] mi);
    mode = m; max_iter = mi; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; max_iter = '0;
    is_steady_state = 1'b0;
    tick(); tick();

    // reset state
    chk_status("rst", 1'b0, 1'b0, 0, 1'b0);
    chk("rst.elem", 32'(elem_sel), 0);
    chk_strobes("rst", 1'b0, 1'b0);
    rst = 1'b0;

    // mode 0, max 5: first start right after reset release
    do_start(2'd0, 10'd5);
    chk_status("m0.s", 1'b1, 1'b0, 0, 1'b0);
    chk_strobes("m0.s", 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) begin start = 1'b1; mode = 2'd1; max_iter = 10'd1; end  // ignored in SIMULATE
      tick();
      start = 1'b0;
      chk_status($sformatf("m0.k%0d", k), k < 5, k == 5, 10'(k), 1'b0);
    end
    tick();
    chk_status("m0.hold", 1'b0, 1'b1, 5, 1'b0);
    chk_strobes("m0.hold", 1'b0, 1'b0);

    // mode 3 behaves as mode 0 (no RNG); restart straight from DONE
    do_start(2'd3, 10'd2);
    chk_strobes("m3", 1'b1, 1'b0);
    tick(); tick();
    chk_status("m3.end", 1'b0, 1'b1, 2, 1'b0);

    // mode 2 round robin, max 2: 32 SIMULATE cycles
    do_start(2'd2, 10'd2);
    chk("m2.elem0", 32'(elem_sel), 0);
    chk_strobes("m2", 1'b1, 1'b0);
    for (int t = 1; t <= 32; t++) begin
      tick();
      chk($sformatf("m2.t%0d.elem", t), 32'(elem_sel), 32'(t % 16));
      chk_status($sformatf("m2.t%0d", t), t < 32, t == 32, 10'(t / 16), 1'b0);
    end

    // mode 1, max 100, steady from iteration 3
    do_start(2'd1, 10'd100);
    chk_strobes("m1", 1'b1, 1'b1);
    for (int k = 0; k < 100; k++) begin
      logic fin;
      is_steady_state = (k >= 3);
      tick();
      fin = (k == 99) || (EXIT && k == 6);
      chk_status($sformatf("m1.k%0d", k), !fin, fin, 10'(k + 1), k >= 6);
      if (fin) break;
    end
    is_steady_state = 1'b0;
    tick();
    chk_status("m1.held", 1'b0, 1'b1, EXIT ? 10'd7 : 10'd100, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_status("m1.abort_done", 1'b0, 1'b0, EXIT ? 10'd7 : 10'd100, 1'b0);

    // steady pattern 1,1,1,0,1,1,1,1 -> rises only after last 1
    do_start(2'd0, 10'd20);
    for (int j = 0; j < 8; j++) begin
      is_steady_state = pat[j][0];
      tick();
      chk_status($sformatf("pat.j%0d", j), !(EXIT && j == 7), EXIT && j == 7,
                 10'(j + 1), j == 7);
    end
    is_steady_state = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_status("pat.abort", 1'b0, 1'b0, 8, 1'b0);

    // abort at iteration 3
    do_start(2'd0, 10'd10);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_status("ab3", 1'b0, 1'b0, 3, 1'b0);
    chk_strobes("ab3", 1'b0, 1'b0);
    tick();
    chk_status("ab3.idle", 1'b0, 1'b0, 3, 1'b0);

    // abort beats the max_iter exit on the final iteration
    do_start(2'd0, 10'd3);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_status("abmax", 1'b0, 1'b0, 2, 1'b0);

    // rst mid-run (mode 2, iteration 2, elem 3) clears immediately
    do_start(2'd2, 10'd10);
    for (int t = 0; t < 35; t++) tick();
    chk_status("rr.pre", 1'b1, 1'b0, 2, 1'b0);
    chk("rr.pre.elem", 32'(elem_sel), 3);
    #2 rst = 1'b1;
    #1;
    chk_status("rr.rst", 1'b0, 1'b0, 0, 1'b0);
    chk("rr.rst.elem", 32'(elem_sel), 0);
    chk_strobes("rr.rst", 1'b0, 1'b0);
    #1 rst = 1'b0;

    // max_iter = 0 goes straight to DONE, no strobes
    do_start(2'd1, 10'd0);
    chk_status("mi0", 1'b0, 1'b1, 0, 1'b0);
    chk_strobes("mi0", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
